// File: rtl/flb_sar_ctrl_if.sv
// flb_sar_ctrl_if: measurement handshake and decoder code bus between the SAR controller and DCO side
interface flb_sar_ctrl_if #(
  parameter int BAND_W = 8,
  parameter int MTRX_W = 8
);
  logic              meas_start;
  logic              meas_done;
  logic              meas_fast;
  logic [BAND_W-1:0] s_band;
  logic [MTRX_W-1:0] s_mtrx;
  modport master (output meas_start, s_band, s_mtrx, input meas_done, meas_fast);
  modport slave  (input meas_start, s_band, s_mtrx, output meas_done, meas_fast);
endinterface

// File: rtl/flb_sar_ctrl.sv
// flb_sar_ctrl: SAR frequency-lock controller (band then matrix code); FLB_TRACK_EN adds post-lock matrix tracking
module flb_sar_ctrl #(
  parameter int BAND_W      = 8,
  parameter int MTRX_W      = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            csr_flb_rst_n,
  input  logic            csr_flb_start,
  flb_sar_ctrl_if.master  bus,
  output logic            flb_busy,
  output logic            flb_lock,
  output logic            flb_err
);
  localparam int MAXW = BAND_W > MTRX_W ? BAND_W : MTRX_W;
  localparam int IW   = MAXW > 1 ? $clog2(MAXW) : 1;
  localparam int MAXC = TIMEOUT_CYC > SETTLE_CYC ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TRIAL  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] MEAS   = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] DECIDE = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
`ifdef FLB_TRACK_EN
  localparam logic [2:0] ADJUST = 3'd7;
`endif

  logic [2:0]        state_q, state_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic [MTRX_W-1:0] mtrx_q, mtrx_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              fast_q, fast_d;
  logic              busy_q, busy_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  logic              start_ok;
`ifdef FLB_TRACK_EN
  logic              track_q, track_d;
  assign start_ok = state_q == IDLE || state_q == DONE || track_q;
`else
  assign start_ok = state_q == IDLE || state_q == DONE;
`endif

  assign bus.meas_start = state_q == MEAS;
  assign bus.s_band     = band_q;
  assign bus.s_mtrx     = mtrx_q;
  assign flb_busy       = busy_q;
  assign flb_lock       = lock_q;
  assign flb_err        = err_q;

  // next-state: start handling, SAR bit trial/decide sequencing, measurement wait with timeout
  always_comb begin
    state_d = state_q;
    band_d  = band_q;
    mtrx_d  = mtrx_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    fast_d  = fast_q;
    busy_d  = busy_q;
    lock_d  = lock_q;
    err_d   = err_q;
`ifdef FLB_TRACK_EN
    track_d = track_q;
`endif
    if (start_ok && csr_flb_start) begin
      state_d = TRIAL;
      busy_d  = 1'b1;
      lock_d  = 1'b0;
      err_d   = 1'b0;
      phase_d = 1'b0;
      idx_d   = IW'(BAND_W - 1);
      band_d  = '0;
      mtrx_d  = MTRX_W'(1) << (MTRX_W - 1);
`ifdef FLB_TRACK_EN
      track_d = 1'b0;
`endif
    end else begin
      case (state_q)
        TRIAL: begin
          if (phase_q) mtrx_d[idx_q] = 1'b1;
          else band_d[idx_q] = 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
        SETTLE: begin
          cnt_d   = cnt_q + CW'(1);
          state_d = cnt_q == CW'(SETTLE_CYC - 1) ? MEAS : SETTLE;
        end
        MEAS: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.meas_done) begin
            fast_d  = bus.meas_fast;
`ifdef FLB_TRACK_EN
            state_d = track_q ? ADJUST : DECIDE;
`else
            state_d = DECIDE;
`endif
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            lock_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = DONE;
`ifdef FLB_TRACK_EN
            track_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DECIDE: begin
          if (!fast_q && phase_q) mtrx_d[idx_q] = 1'b0;
          if (!fast_q && !phase_q) band_d[idx_q] = 1'b0;
          if (idx_q != '0) begin
            idx_d   = idx_q - IW'(1);
            state_d = TRIAL;
          end else if (!phase_q) begin
            phase_d = 1'b1;
            mtrx_d  = '0;
            idx_d   = IW'(MTRX_W - 1);
            state_d = TRIAL;
          end else begin
            lock_d  = 1'b1;
            busy_d  = 1'b0;
`ifdef FLB_TRACK_EN
            track_d = 1'b1;
            cnt_d   = '0;
            state_d = SETTLE;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef FLB_TRACK_EN
        ADJUST: begin
          mtrx_d  = fast_q ? (&mtrx_q ? mtrx_q : mtrx_q + MTRX_W'(1))
                           : (|mtrx_q ? mtrx_q - MTRX_W'(1) : mtrx_q);
          cnt_d   = '0;
          state_d = SETTLE;
        end
`endif
        default: ;
      endcase
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!csr_flb_rst_n) begin
      state_q <= IDLE;
      band_q  <= '0;
      mtrx_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      fast_q  <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FLB_TRACK_EN
      track_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
      mtrx_q  <= mtrx_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      fast_q  <= fast_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
`ifdef FLB_TRACK_EN
      track_q <= track_d;
`endif
    end
  end
endmodule

// File: tb/tb_flb_sar_ctrl.sv
// tb_flb_sar_ctrl: scoreboard bench for flb_sar_ctrl with a DCO responder model
module tb_flb_sar_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b1;
  logic busy, lock, err;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;
  int rcnt = 0;

  typedef struct packed {
    logic       fin;
    logic [7:0] band;
    logic [7:0] mtrx;
    logic       lock;
    logic       err;
    int         nmeas;
  } exp_t;
  exp_t q[$];

  flb_sar_ctrl_if #(.BAND_W(8), .MTRX_W(8)) bus ();

  flb_sar_ctrl #(.BAND_W(8), .MTRX_W(8), .SETTLE_CYC(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .csr_flb_rst_n(rst_n),
    .csr_flb_start(start),
    .bus(bus),
    .flb_busy(busy),
    .flb_lock(lock),
    .flb_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input logic fin, input logic [7:0] b, input logic [7:0] m,
                               input logic l, input logic e, input int n);
    q.push_back('{fin, b, m, l, e, n});
  endfunction

  // DCO model: answers each meas_start three cycles later; mode 0 thresholds, 1 always fast, 2 never fast, 3 hang on 3rd
  initial begin : responder
    logic f;
    bus.meas_done = 1'b0;
    bus.meas_fast = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) rcnt = 0;
      if (bus.meas_start) begin
        if (busy) rcnt++;
        f = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 :
            (busy && rcnt <= 8) ? (bus.s_band <= 8'hD5) : (bus.s_mtrx <= 8'h3A);
        if (!(mode == 3 && busy && rcnt == 3)) begin
          repeat (3) @(posedge clk);
          #1 bus.meas_done = 1'b1;
          bus.meas_fast = f;
          @(posedge clk);
          #1 bus.meas_done = 1'b0;
          bus.meas_fast = 1'b0;
        end
      end
    end
  end

  // monitor: pops expected trial codes on meas_start and final results when busy drops
  initial begin : monitor
    int last;
    int nm;
    logic busy_prev;
    exp_t e;
    last = -1;
    nm = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy_prev && busy === 1'b1) begin
        last = -1;
        nm = 0;
      end
      if (bus.meas_start === 1'b1 && busy === 1'b1) begin
        if (last >= 0) check("meas_spacing", cyc - last, 10);
        last = cyc;
        nm++;
        if (q.size() == 0 || q[0].fin) begin
          n_chk++;
          n_fail++;
          $display("FAIL meas_unexpected: got meas_start band 0x%0h mtrx 0x%0h, required none", bus.s_band, bus.s_mtrx);
        end else begin
          e = q.pop_front();
          check("trial_band", bus.s_band, e.band);
          check("trial_mtrx", bus.s_mtrx, e.mtrx);
        end
      end
      if (busy_prev && busy === 1'b0) begin
        if (q.size() == 0 || !q[0].fin) begin
          n_chk++;
          n_fail++;
          $display("FAIL early_end: got busy=0 with %0d trials outstanding, required busy=1", q.size());
          while (q.size() > 0 && !q[0].fin) void'(q.pop_front());
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          check("final_band", bus.s_band, e.band);
          check("final_mtrx", bus.s_mtrx, e.mtrx);
          check("final_lock", lock, e.lock);
          check("final_err", err, e.err);
          check("meas_count", nm, e.nmeas);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic push_table(input logic [7:0] b[16], input logic [7:0] m[16],
                            input logic [7:0] fb, input logic [7:0] fm, input logic l, input logic e, input int n);
    for (int i = 0; i < n; i++) push(1'b0, b[i], m[i], 1'b0, 1'b0, 0);
    push(1'b1, fb, fm, l, e, n);
  endtask

  task automatic run(input int m, input logic mid_start);
    int i;
    mode = m;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    if (mid_start) begin
      repeat (40) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    i = 0;
    while (busy && i < 400) begin
      @(posedge clk);
      #1 i++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL search_bound: got busy=1 after 400 cycles, required 0");
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef FLB_TRACK_EN
  task automatic track_step(input string name, input logic [7:0] exp);
    int i;
    i = 0;
    while (bus.meas_done !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check({name, "_resp"}, bus.meas_done, 1);
    repeat (2) @(posedge clk);
    #1 check(name, bus.s_mtrx, exp);
    check({name, "_lock"}, lock, 1);
    check({name, "_busy"}, busy, 0);
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish after 200000 time units, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] b[16];
    logic [7:0] m[16];
    logic [7:0] t;
    repeat (2) @(posedge clk);
    #1 check("rst_busy", busy, 0);
    check("rst_lock", lock, 0);
    check("rst_err", err, 0);
    check("rst_band", bus.s_band, 0);
    check("rst_mtrx", bus.s_mtrx, 0);
    check("rst_meas_start", bus.meas_start, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 check("idle_busy", busy, 0);

    b = '{8'h80, 8'hC0, 8'hE0, 8'hD0, 8'hD8, 8'hD4, 8'hD6, 8'hD5,
          8'hD5, 8'hD5, 8'hD5, 8'hD5, 8'hD5, 8'hD5, 8'hD5, 8'hD5};
    m = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
          8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3A, 8'h3B};
    push_table(b, m, 8'hD5, 8'h3A, 1'b1, 1'b0, 16);
    run(0, 1'b0);

    push_table(b, m, 8'hD5, 8'h3A, 1'b1, 1'b0, 16);
    run(0, 1'b1);

    push_table(b, m, 8'hE0, 8'h80, 1'b0, 1'b1, 3);
    run(3, 1'b0);

    for (int i = 0; i < 8; i++) begin
      t = 8'h80 >> i;
      b[i] = t;
      m[i] = 8'h80;
      b[i+8] = 8'h00;
      m[i+8] = t;
    end
    push_table(b, m, 8'h00, 8'h00, 1'b1, 1'b0, 16);
    run(2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      t = 8'hFF << (7 - i);
      b[i] = t;
      m[i] = 8'h80;
      b[i+8] = 8'hFF;
      m[i+8] = t;
    end
    push_table(b, m, 8'hFF, 8'hFF, 1'b1, 1'b0, 16);
    run(1, 1'b0);

`ifdef FLB_TRACK_EN
    track_step("track_sat_hi", 8'hFF);
    mode = 2;
    track_step("track_dec1", 8'hFE);
    track_step("track_dec2", 8'hFD);
`endif

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
